// File: rtl/rib_wb_arbiter_if.sv
// Core-side RIB signals and Wishbone classic master bus of the fetch/data arbiter.
// Signal directions are named from the arbiter's point of view (_i in, _o out).
// master: arbiter view (drives Wishbone); slave: core + Wishbone target view.
interface rib_wb_arbiter_if;
  // instruction fetch port
  logic [31:0] rib_pc_addr_i;
  logic [31:0] rib_pc_data_o;
  // data access port
  logic        rib_ex_req_i;
  logic        rib_ex_we_i;
  logic [31:0] rib_ex_addr_i;
  logic [31:0] rib_ex_data_i;
  logic [31:0] rib_ex_data_o;
  logic        rib_hold_flag_o;
  // Wishbone classic master
  logic        core_cyc_o;
  logic        core_stb_o;
  logic        core_we_o;
  logic [3:0]  core_sel_o;
  logic [31:0] core_addr_o;
  logic [31:0] core_data_o;
  logic [31:0] core_data_i;
  logic        core_ack_i;
  // sticky timeout indication
  logic        bus_err_o;

  modport master (
    input  rib_pc_addr_i, rib_ex_req_i, rib_ex_we_i, rib_ex_addr_i, rib_ex_data_i,
    input  core_data_i, core_ack_i,
    output rib_pc_data_o, rib_ex_data_o, rib_hold_flag_o,
    output core_cyc_o, core_stb_o, core_we_o, core_sel_o, core_addr_o, core_data_o,
    output bus_err_o
  );

  modport slave (
    output rib_pc_addr_i, rib_ex_req_i, rib_ex_we_i, rib_ex_addr_i, rib_ex_data_i,
    output core_data_i, core_ack_i,
    input  rib_pc_data_o, rib_ex_data_o, rib_hold_flag_o,
    input  core_cyc_o, core_stb_o, core_we_o, core_sel_o, core_addr_o, core_data_o,
    input  bus_err_o
  );
endinterface

// File: rtl/rib_wb_arbiter.sv
// Arbitrates core instruction fetch and data access onto one Wishbone classic master port.
// Latency: cyc/stb rise the cycle after a request; hold drops the cycle after ack (2 cycles min).
// Backpressure: core is stalled via rib_hold_flag_o; accesses without ack abort after TIMEOUT cycles.
module rib_wb_arbiter #(
  parameter int unsigned TIMEOUT   = 255,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic             clk,
  input  logic             rst_n,
  rib_wb_arbiter_if.master io_bus
);

  // last wait count before an unacknowledged access is abandoned
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    FETCH = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic        r_fetch_valid;
  logic [31:0] r_fetch_addr;
  logic        r_data_done;
  logic [15:0] r_wait_cnt;
  logic        r_bus_err;
  logic [31:0] r_pc_data;
  logic [31:0] r_ex_data;

  logic        w_need_data;
  logic        w_need_fetch;
  logic        w_hold;
  logic        w_busy;
  logic        w_ack;
  logic        w_expire;
  logic        w_done;

  // a data request is pending until its access has completed for this instruction
  assign w_need_data  = io_bus.rib_ex_req_i && !r_data_done;
  // the cached instruction is only good for the address it was fetched from
  assign w_need_fetch = !r_fetch_valid || (io_bus.rib_pc_addr_i != r_fetch_addr);
  assign w_hold       = w_need_data || w_need_fetch;

  // ack beats the timeout when both land in the same cycle
  assign w_busy   = (r_state != IDLE);
  assign w_ack    = w_busy && io_bus.core_ack_i;
  assign w_expire = w_busy && !io_bus.core_ack_i && (r_wait_cnt == CNT_LAST);
  assign w_done   = w_ack || w_expire;

  assign io_bus.rib_hold_flag_o = w_hold;
  assign io_bus.rib_pc_data_o   = r_pc_data;
  assign io_bus.rib_ex_data_o   = r_ex_data;
  assign io_bus.bus_err_o       = r_bus_err;

  // state register; reset drops any in-flight access immediately
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // next state and Wishbone outputs; IDLE always separates two accesses
  always_comb begin
    w_state_nxt        = r_state;
    io_bus.core_cyc_o  = 1'b0;
    io_bus.core_stb_o  = 1'b0;
    io_bus.core_we_o   = 1'b0;
    io_bus.core_sel_o  = 4'h0;
    io_bus.core_addr_o = 32'h0;
    io_bus.core_data_o = 32'h0;
    unique case (r_state)
      IDLE: begin
        if (w_need_data) begin
          w_state_nxt = DATA;
        end else if (w_need_fetch) begin
          w_state_nxt = FETCH;
        end
      end
      DATA: begin
        io_bus.core_cyc_o  = 1'b1;
        io_bus.core_stb_o  = 1'b1;
        io_bus.core_we_o   = io_bus.rib_ex_we_i;
        io_bus.core_sel_o  = 4'hF;
        io_bus.core_addr_o = io_bus.rib_ex_addr_i;
        io_bus.core_data_o = io_bus.rib_ex_data_i;
        if (w_done) begin
          w_state_nxt = IDLE;
        end
      end
      FETCH: begin
        io_bus.core_cyc_o  = 1'b1;
        io_bus.core_stb_o  = 1'b1;
        io_bus.core_sel_o  = 4'hF;
        io_bus.core_addr_o = io_bus.rib_pc_addr_i;
        if (w_done) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // wait counter: held at zero outside an access so every access starts from zero
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wait_cnt <= 16'h0;
    end else if (!w_busy || w_done) begin
      r_wait_cnt <= 16'h0;
    end else begin
      r_wait_cnt <= r_wait_cnt + 16'h1;
    end
  end

  // fetch result and the address it belongs to; a timed-out fetch yields a NOP
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc_data     <= 32'h0;
      r_fetch_addr  <= 32'h0;
      r_fetch_valid <= 1'b0;
    end else if ((r_state == FETCH) && w_done) begin
      r_pc_data     <= w_ack ? io_bus.core_data_i : NOP_INSTR;
      r_fetch_addr  <= io_bus.rib_pc_addr_i;
      r_fetch_valid <= 1'b1;
    end
  end

  // read data for the core; writes leave the last read value in place
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ex_data <= 32'h0;
    end else if ((r_state == DATA) && w_done && !io_bus.rib_ex_we_i) begin
      r_ex_data <= w_ack ? io_bus.core_data_i : 32'h0;
    end
  end

  // data_done marks the current instruction's access as served until the pipeline moves on
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data_done <= 1'b0;
    end else if (!io_bus.rib_ex_req_i || !w_hold) begin
      r_data_done <= 1'b0;
    end else if ((r_state == DATA) && w_done) begin
      r_data_done <= 1'b1;
    end
  end

  // sticky error: any abandoned access is remembered until reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bus_err <= 1'b0;
    end else if (w_expire) begin
      r_bus_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_rib_wb_arbiter.sv
// Directed bench for rib_wb_arbiter: fetch, data priority, write, timeout, reset, ack/timeout race.
// Inputs change 1 time unit after the rising edge; outputs are checked in that same window.
// The bench plays the Wishbone target by driving ack/data by hand in the cycle it wants.
module tb_rib_wb_arbiter;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  rib_wb_arbiter_if bus_if ();

  rib_wb_arbiter #(
    .TIMEOUT   (8),
    .NOP_INSTR (32'h00000013)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // watchdog so the run always ends
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n_cyc;
    n_chk  = 0;
    n_pass = 0;
    rst_n                = 1'b0;
    bus_if.rib_pc_addr_i = 32'h0;
    bus_if.rib_ex_req_i  = 1'b0;
    bus_if.rib_ex_we_i   = 1'b0;
    bus_if.rib_ex_addr_i = 32'h0;
    bus_if.rib_ex_data_i = 32'h0;
    bus_if.core_data_i   = 32'h0;
    bus_if.core_ack_i    = 1'b0;
    tick();
    tick();

    // reset state
    chk("rst_cyc",     32'(bus_if.core_cyc_o), 32'h0);
    chk("rst_err",     32'(bus_if.bus_err_o), 32'h0);
    chk("rst_pc_data", bus_if.rib_pc_data_o, 32'h0);
    chk("rst_ex_data", bus_if.rib_ex_data_o, 32'h0);
    chk("rst_hold",    32'(bus_if.rib_hold_flag_o), 32'h1);

    // zero-wait fetch at 0x0
    rst_n = 1'b1;
    #1;
    chk("f0_idle_cyc",  32'(bus_if.core_cyc_o), 32'h0);
    chk("f0_idle_sel",  32'(bus_if.core_sel_o), 32'h0);
    chk("f0_idle_addr", bus_if.core_addr_o, 32'h0);
    chk("f0_hold_c1",   32'(bus_if.rib_hold_flag_o), 32'h1);
    tick();
    chk("f0_cyc",     32'(bus_if.core_cyc_o), 32'h1);
    chk("f0_stb",     32'(bus_if.core_stb_o), 32'h1);
    chk("f0_we",      32'(bus_if.core_we_o), 32'h0);
    chk("f0_sel",     32'(bus_if.core_sel_o), 32'hF);
    chk("f0_hold_c2", 32'(bus_if.rib_hold_flag_o), 32'h1);
    bus_if.core_ack_i  = 1'b1;
    bus_if.core_data_i = 32'h00500093;
    tick();
    bus_if.core_ack_i = 1'b0;
    chk("f0_pc_data", bus_if.rib_pc_data_o, 32'h00500093);
    chk("f0_hold_c3", 32'(bus_if.rib_hold_flag_o), 32'h0);
    chk("f0_cyc_end", 32'(bus_if.core_cyc_o), 32'h0);

    // data read takes priority over a pending fetch at 0x4
    bus_if.rib_pc_addr_i = 32'h4;
    bus_if.rib_ex_req_i  = 1'b1;
    bus_if.rib_ex_we_i   = 1'b0;
    bus_if.rib_ex_addr_i = 32'h1000;
    #1;
    chk("pr_hold_idle", 32'(bus_if.rib_hold_flag_o), 32'h1);
    tick();
    chk("pr_data_cyc",  32'(bus_if.core_cyc_o), 32'h1);
    chk("pr_data_addr", bus_if.core_addr_o, 32'h1000);
    chk("pr_data_we",   32'(bus_if.core_we_o), 32'h0);
    bus_if.core_ack_i  = 1'b1;
    bus_if.core_data_i = 32'hCAFEF00D;
    tick();
    bus_if.core_ack_i = 1'b0;
    chk("pr_ex_data",  bus_if.rib_ex_data_o, 32'hCAFEF00D);
    chk("pr_gap_cyc",  32'(bus_if.core_cyc_o), 32'h0);
    chk("pr_gap_hold", 32'(bus_if.rib_hold_flag_o), 32'h1);
    tick();
    chk("pr_fetch_addr", bus_if.core_addr_o, 32'h4);
    chk("pr_fetch_we",   32'(bus_if.core_we_o), 32'h0);
    chk("pr_fetch_hold", 32'(bus_if.rib_hold_flag_o), 32'h1);
    bus_if.core_ack_i  = 1'b1;
    bus_if.core_data_i = 32'h00A00113;
    tick();
    bus_if.core_ack_i = 1'b0;
    chk("pr_pc_data",  bus_if.rib_pc_data_o, 32'h00A00113);
    chk("pr_hold_end", 32'(bus_if.rib_hold_flag_o), 32'h0);
    bus_if.rib_ex_req_i = 1'b0;
    tick();

    // write with ack in the third cycle
    bus_if.rib_ex_req_i  = 1'b1;
    bus_if.rib_ex_we_i   = 1'b1;
    bus_if.rib_ex_addr_i = 32'h2000;
    bus_if.rib_ex_data_i = 32'hDEADBEEF;
    tick();
    for (int i = 0; i < 3; i++) begin
      chk("wr_cyc",  32'(bus_if.core_cyc_o), 32'h1);
      chk("wr_we",   32'(bus_if.core_we_o), 32'h1);
      chk("wr_data", bus_if.core_data_o, 32'hDEADBEEF);
      chk("wr_addr", bus_if.core_addr_o, 32'h2000);
      if (i == 2) begin
        bus_if.core_ack_i  = 1'b1;
        bus_if.core_data_i = 32'h11111111;
      end
      tick();
    end
    bus_if.core_ack_i = 1'b0;
    chk("wr_ex_data_kept", bus_if.rib_ex_data_o, 32'hCAFEF00D);
    chk("wr_cyc_end",      32'(bus_if.core_cyc_o), 32'h0);
    chk("wr_hold_end",     32'(bus_if.rib_hold_flag_o), 32'h0);
    chk("wr_err",          32'(bus_if.bus_err_o), 32'h0);
    bus_if.rib_ex_req_i = 1'b0;
    bus_if.rib_ex_we_i  = 1'b0;
    tick();

    // fetch timeout at 0x8, no ack ever
    bus_if.rib_pc_addr_i = 32'h8;
    tick();
    n_cyc = 0;
    while (bus_if.core_cyc_o && n_cyc < 20) begin
      n_cyc++;
      tick();
    end
    chk("to_cyc_cycles", 32'(n_cyc), 32'd8);
    chk("to_pc_data",    bus_if.rib_pc_data_o, 32'h00000013);
    chk("to_err",        32'(bus_if.bus_err_o), 32'h1);
    chk("to_hold",       32'(bus_if.rib_hold_flag_o), 32'h0);
    tick();
    tick();
    chk("to_err_sticky", 32'(bus_if.bus_err_o), 32'h1);

    // reset in the second wait cycle of a data read, with a stray ack around it
    bus_if.rib_ex_req_i  = 1'b1;
    bus_if.rib_ex_addr_i = 32'h3000;
    tick();
    tick();
    chk("rs_cyc_before", 32'(bus_if.core_cyc_o), 32'h1);
    rst_n              = 1'b0;
    bus_if.core_ack_i  = 1'b1;
    bus_if.core_data_i = 32'hBADBAD00;
    tick();
    chk("rs_cyc_after", 32'(bus_if.core_cyc_o), 32'h0);
    chk("rs_err",       32'(bus_if.bus_err_o), 32'h0);
    chk("rs_ex_data",   bus_if.rib_ex_data_o, 32'h0);
    chk("rs_hold",      32'(bus_if.rib_hold_flag_o), 32'h1);
    rst_n                = 1'b1;
    bus_if.rib_ex_req_i  = 1'b0;
    bus_if.rib_pc_addr_i = 32'h40;
    tick();
    bus_if.core_ack_i = 1'b0;
    chk("rs_fetch_cyc",  32'(bus_if.core_cyc_o), 32'h1);
    chk("rs_fetch_we",   32'(bus_if.core_we_o), 32'h0);
    chk("rs_fetch_addr", bus_if.core_addr_o, 32'h40);
    chk("rs_late_ex",    bus_if.rib_ex_data_o, 32'h0);
    chk("rs_late_pc",    bus_if.rib_pc_data_o, 32'h0);

    // same fetch: ack arrives exactly on the timeout cycle
    for (int i = 0; i < 7; i++) begin
      tick();
    end
    chk("race_cyc_last", 32'(bus_if.core_cyc_o), 32'h1);
    bus_if.core_ack_i  = 1'b1;
    bus_if.core_data_i = 32'h12345678;
    tick();
    bus_if.core_ack_i = 1'b0;
    chk("race_pc_data", bus_if.rib_pc_data_o, 32'h12345678);
    chk("race_err",     32'(bus_if.bus_err_o), 32'h0);
    chk("race_cyc_end", 32'(bus_if.core_cyc_o), 32'h0);
    chk("race_hold",    32'(bus_if.rib_hold_flag_o), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/rib_wb_arbiter.md
RIB_WB_ARBITER -- requirements
Module: rib_wb_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: number of cycles without ack before a bus access is aborted.
REQ-002 Parameter NOP_INSTR, default 32'h00000013: instruction word returned on a fetch timeout.
REQ-003 Port clk  in  1: core clock; all state changes on its rising edge.
REQ-004 Port rst_n  in  1: reset, synchronous, active-low.
REQ-005 Port rib_pc_addr_i  in  32: fetch address from the core.
REQ-006 Port rib_pc_data_o  out  32: fetched instruction to the core.
REQ-007 Port rib_ex_req_i / rib_ex_we_i  in  1 each: data access request and write enable.
REQ-008 Port rib_ex_addr_i / rib_ex_data_i  in  32 each: data address and write data.
REQ-009 Port rib_ex_data_o  out  32: read data to the core.
REQ-010 Port rib_hold_flag_o  out  1: pipeline stall to the core.
REQ-011 Ports core_cyc_o, core_stb_o, core_we_o  out  1 each: Wishbone classic master controls.
REQ-012 Ports core_sel_o  out  4; core_addr_o, core_data_o  out  32: Wishbone byte selects, address and write data.
REQ-013 Ports core_data_i  in  32; core_ack_i  in  1: Wishbone read data and acknowledge.
REQ-014 Port bus_err_o  out  1: sticky flag, set by any timeout.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, DATA and FETCH.
REQ-016 need_data SHALL be rib_ex_req_i && !data_done.
REQ-017 need_fetch SHALL be !fetch_valid || (rib_pc_addr_i != fetch_addr).
REQ-018 rib_hold_flag_o SHALL equal need_data || need_fetch, combinational, in every state.
REQ-019 In IDLE, if need_data the next state SHALL be DATA; else if need_fetch, FETCH; else IDLE. Data has priority over fetch.
REQ-020 In DATA, outputs SHALL be cyc=stb=1, we=rib_ex_we_i, sel=4'hF, addr=rib_ex_addr_i, data_o=rib_ex_data_i.
REQ-021 In FETCH, outputs SHALL be cyc=stb=1, we=0, sel=4'hF, addr=rib_pc_addr_i.
REQ-022 In IDLE, cyc, stb and we SHALL be 0; sel, addr and data_o SHALL be 0.
REQ-023 DATA with core_ack_i: if reading, rib_ex_data_o <= core_data_i (writes leave it unchanged); data_done <= 1; next state IDLE.
REQ-024 FETCH with core_ack_i: rib_pc_data_o <= core_data_i, fetch_addr <= rib_pc_addr_i, fetch_valid <= 1; next state IDLE.
REQ-025 A 16-bit wait counter SHALL clear on entry to DATA or FETCH and increment each cycle without ack.
REQ-026 When the counter reaches TIMEOUT-1 with no ack: complete the access as if acked, with data 32'h0 for DATA or NOP_INSTR for FETCH; set bus_err_o; return to IDLE.
REQ-027 If ack and timeout occur in the same cycle, ack SHALL win and bus_err_o SHALL stay unchanged.
REQ-028 data_done SHALL clear on any edge where rib_hold_flag_o is 0 (pipeline advanced); it SHALL also clear whenever rib_ex_req_i is 0.
REQ-029 Changes to rib_pc_addr_i during FETCH SHALL NOT abort the access; after completion, the address mismatch re-triggers a fetch.
REQ-030 Latency: the request is seen in cycle N, cyc/stb are high from N+1, ack arrives at cycle K, and hold drops combinationally in K+1. Zero-wait minimum hold is 2 cycles per access.
REQ-031 cyc and stb SHALL deassert for at least one cycle (IDLE) between consecutive accesses.

Reset
REQ-032 On clk edge with rst_n=0: state=IDLE, fetch_valid=0, fetch_addr=0, data_done=0, counter=0, bus_err_o=0, rib_pc_data_o=0, rib_ex_data_o=0.
REQ-033 Reset asserted mid-access SHALL drop cyc/stb on the next edge; a late ack after reset SHALL be ignored.
REQ-034 After reset, hold SHALL be 1, because fetch_valid=0 forces a fetch.

Verification
REQ-035 Fetch, zero-wait: pc=0x0, ack in the first cycle of cyc, data 0x00500093 -> rib_pc_data_o=0x00500093; hold high for 2 cycles, then low.
REQ-036 Priority: at IDLE, pc changes to 0x4 while ex_req=1, we=0, addr=0x1000 -> DATA runs first, then FETCH at 0x4; hold stays high through both.
REQ-037 Write: ex_req=1, we=1, addr=0x2000, data=0xDEADBEEF, ack after 3 cycles -> core_we_o=1 and core_data_o=0xDEADBEEF for 3 cycles; rib_ex_data_o unchanged.
REQ-038 Timeout: fetch with no ack, TIMEOUT=8 -> cyc drops after 8 cycles; rib_pc_data_o=0x00000013; bus_err_o=1 and sticky.
REQ-039 Ack and timeout in the same cycle, ack data 0x12345678 -> data latched as 0x12345678; bus_err_o stays 0.
REQ-040 Reset mid-DATA access (cycle 2 of the wait) -> cyc=0 on the next edge; after rst_n rises, the first access is a FETCH of rib_pc_addr_i.
